key_conditioner: RTL and testbench
==================================

// Module: key_conditioner
// PURPOSE
//  Conditions the raw active-low DE-board push buttons (set, start/stop) before
//  they reach the timer state machine.
//  - Per key: synchronise to clk, debounce, emit one-cycle press/release pulses.
//  - Also provides a long-press hold level and an auto-repeat pulse for fast
//    minute/second entry.
//  - Sits between the KEY pins and TimerController in EggTimerController.
// PARAMETERS
//  NUM_KEYS         2           number of independent key channels
//  DEBOUNCE_CYCLES  1_000_000   consecutive stable cycles to accept a change (20 ms @ 50 MHz); >=1
//  HOLD_CYCLES      50_000_000  pressed cycles before hold asserts (1 s); > DEBOUNCE_CYCLES
//  REPEAT_CYCLES    12_500_000  repeat_pulse period while hold is high (250 ms); >=1
//  CNT_WIDTH        26          width of internal counters; must hold max(HOLD_CYCLES, REPEAT_CYCLES)
// PORTS
//  clk            in   1         CLOCK_50 domain, all logic rising-edge
//  reset          in   1         asynchronous, active-low (0 = reset)
//  keys_n         in   NUM_KEYS  raw buttons, 0 = pressed, asynchronous to clk
//  pressed        out  NUM_KEYS  debounced level, 1 = pressed
//  press_pulse    out  NUM_KEYS  1 cycle high on accepted press
//  release_pulse  out  NUM_KEYS  1 cycle high on accepted release
//  hold           out  NUM_KEYS  1 while pressed continuously >= HOLD_CYCLES
//  repeat_pulse   out  NUM_KEYS  1 cycle high every REPEAT_CYCLES while hold
// BEHAVIOUR
//  - Reset: sync flops = 1 (released); pressed, press_pulse, release_pulse,
//    hold, repeat_pulse = 0; all counters = 0.
//  - Sync: 2-flop synchroniser per key, no logic between stages; raw_s = ~sync2.
//  - Debounce, per channel:
//    - raw_s == pressed: db_cnt cleared.
//    - Otherwise db_cnt increments each cycle.
//    - When db_cnt reaches DEBOUNCE_CYCLES-1 with raw_s still differing, the
//      next edge toggles pressed and clears db_cnt.
//    - Any glitch shorter than DEBOUNCE_CYCLES restarts the count; no output change.
//  - Latency: clean edge on keys_n -> pressed changes DEBOUNCE_CYCLES+2 cycles later.
//  - Pulses: registered. press_pulse and release_pulse are high in the same cycle
//    pressed is first 1 (respectively 0). Each is exactly 1 cycle per accepted
//    edge; never both high at once.
//  - Hold counter, per channel:
//    - Counts while pressed; cleared while !pressed.
//    - Saturates at HOLD_CYCLES; no wrap.
//    - hold rises the cycle the count reaches HOLD_CYCLES.
//  - Repeat:
//    - rep_cnt runs only while hold.
//    - First repeat_pulse arrives REPEAT_CYCLES cycles after hold rises.
//    - rep_cnt wraps to 0 on each pulse.
//  - Release: hold, rep_cnt and hold count clear in the same cycle release_pulse
//    is high. No repeat_pulse coincides with release_pulse.
//  - Channels are fully independent; simultaneous presses on several keys each
//    produce their own pulses in the same cycle.
//  - Reset mid-operation: all outputs drop immediately (async). If a key is still
//    held after reset deasserts, it is treated as a fresh press: press_pulse after
//    DEBOUNCE_CYCLES+2 cycles, and hold re-times from zero.
//  - No combinational path from keys_n to any output.
// STRUCTURE
//  - egg_timer_pkg holds CLK_HZ = 50_000_000 and the default DEBOUNCE/HOLD/REPEAT
//    cycle constants, shared with ClockDivider.
//  - One sub-module, key_channel (sync + debounce + hold/repeat for one key).
//  - key_conditioner instantiates NUM_KEYS copies in a generate loop.
// TESTING (bench params: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5)
//  1 Reset, keys_n=2'b11 for 50 cycles -> all outputs 0, no pulses.
//  2 keys_n[0] 1->0 held -> pressed[0]=1 and press_pulse[0] for 1 cycle exactly 6
//    cycles after the edge; release -> release_pulse[0] 6 cycles after the release edge.
//  3 keys_n[1] bounces (0 for 3 cycles, 1 for 2, 0 for 3, then 1) -> no change on
//    pressed[1] and no pulses.
//  4 keys_n[0] held 50 cycles -> hold[0] 20 cycles after pressed[0] rises;
//    repeat_pulse[0] at +5, +10, +15...; release clears hold the same cycle as
//    release_pulse.
//  5 Both keys pressed on the same cycle -> press_pulse=2'b11 in one cycle; later
//    release key 0 only -> key 1 pressed and hold unaffected.
//  6 Key held, assert reset for 3 cycles mid-hold -> outputs 0 at once; after
//    release of reset, press_pulse again 6 cycles later and hold 20 cycles after that.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// Shared egg-timer constants and the per-key event bundle.
// Cycle counts assume the 50 MHz board clock.
package egg_timer_pkg;

    localparam int CLK_HZ                = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES   = CLK_HZ / 50;   // 20 ms
    localparam int DEF_HOLD_CYCLES       = CLK_HZ;        // 1 s
    localparam int DEF_REPEAT_CYCLES     = CLK_HZ / 4;    // 250 ms
    localparam int DEF_CNT_WIDTH         = 26;

    typedef struct packed {
        logic pressed;
        logic press_pulse;
        logic release_pulse;
        logic hold;
        logic repeat_pulse;
    } key_evt_t;

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchroniser, debounce, edge pulses,
// long-press hold level and auto-repeat pulse.
module key_channel
    import egg_timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     key_n_i,
    output key_evt_t evt_o
);

    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] REP_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

    logic                 sync1_q, sync2_q;
    logic                 raw_s, hold_s;
    logic                 pressed_q, pressed_d;
    logic                 press_q, press_d;
    logic                 rel_q, rel_d;
    logic                 rep_q, rep_d;
    logic [CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;

    assign raw_s  = ~sync2_q;
    assign hold_s = (hold_cnt_q == HOLD_MAX);

    always_comb begin
        pressed_d  = pressed_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        db_cnt_d   = '0;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        rep_d      = 1'b0;

        if (raw_s != pressed_q) begin
            if (db_cnt_q == DB_LAST) begin
                pressed_d = raw_s;
                press_d   = raw_s;
                rel_d     = ~raw_s;
            end else begin
                db_cnt_d = db_cnt_q + ONE;
            end
        end

        // Gating on pressed_d clears hold/repeat on the release edge itself,
        // so no repeat pulse can land alongside the release pulse.
        if (pressed_q && pressed_d) begin
            hold_cnt_d = hold_s ? hold_cnt_q : hold_cnt_q + ONE;
            if (hold_s) begin
                if (rep_cnt_q == REP_LAST) begin
                    rep_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            pressed_q  <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            rep_q      <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
        end else begin
            sync1_q    <= key_n_i;
            sync2_q    <= sync1_q;
            pressed_q  <= pressed_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            rep_q      <= rep_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    assign evt_o.pressed       = pressed_q;
    assign evt_o.press_pulse   = press_q;
    assign evt_o.release_pulse = rel_q;
    assign evt_o.hold          = hold_s;
    assign evt_o.repeat_pulse  = rep_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low board keys for the timer state machine;
// one independent key_channel per key.
module key_conditioner
    import egg_timer_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_n,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] hold,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    key_evt_t [NUM_KEYS-1:0] evt;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_chan (
            .clk_i   (clk),
            .rst_ni  (reset),
            .key_n_i (keys_n[k]),
            .evt_o   (evt[k])
        );

        assign pressed[k]       = evt[k].pressed;
        assign press_pulse[k]   = evt[k].press_pulse;
        assign release_pulse[k] = evt[k].release_pulse;
        assign hold[k]          = evt[k].hold;
        assign repeat_pulse[k]  = evt[k].repeat_pulse;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner; expected output events are queued with
// their cycle number and a monitor pops them whenever the outputs show activity.
module tb_key_conditioner;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int HC = 20;
    localparam int RC = 5;
    localparam int CW = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys_n = '1;
    logic [NK-1:0] pressed, press_pulse, release_pulse, hold, repeat_pulse;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC),
        .REPEAT_CYCLES   (RC),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .keys_n        (keys_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .hold          (hold),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] prs, pp, rp, hd, rep;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    logic [1:0] prev_prs = '0;
    logic [1:0] prev_hd  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any pulse, or a change of pressed/hold, is an output event.
    always @(negedge clk) begin
        ev_t e;
        if ((press_pulse | release_pulse | repeat_pulse) != '0 ||
            pressed != prev_prs || hold != prev_hd) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d prs=%b pp=%b rp=%b hd=%b rep=%b",
                         cyc, pressed, press_pulse, release_pulse, hold, repeat_pulse);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.prs !== pressed || e.pp !== press_pulse ||
                    e.rp !== release_pulse || e.hd !== hold || e.rep !== repeat_pulse) begin
                    failures++;
                    $display("FAIL event got cyc=%0d prs=%b pp=%b rp=%b hd=%b rep=%b exp cyc=%0d prs=%b pp=%b rp=%b hd=%b rep=%b",
                             cyc, pressed, press_pulse, release_pulse, hold, repeat_pulse,
                             e.cyc, e.prs, e.pp, e.rp, e.hd, e.rep);
                end
            end
        end
        prev_prs = pressed;
        prev_hd  = hold;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [1:0] prs, input logic [1:0] pp,
                        input logic [1:0] rp, input logic [1:0] hd, input logic [1:0] rep);
        ev_t e;
        e.cyc = c; e.prs = prs; e.pp = pp; e.rp = rp; e.hd = hd; e.rep = rep;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, act, expv);
        end
    endtask

    initial begin
        int c;
        int d;
        #1 reset = 1'b0;
        step(2);
        chk("reset_state", {pressed, press_pulse, release_pulse, hold, repeat_pulse}, 10'b0);
        reset = 1'b1;

        // 1: idle after reset
        step(50);
        chk("idle_outputs", {pressed, press_pulse, release_pulse, hold, repeat_pulse}, 10'b0);

        // 2: clean press and release on key 0
        c = cyc;
        keys_n[0] = 1'b0;
        push(c + 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        step(10);
        keys_n[0] = 1'b1;
        push(c + 16, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step(16);

        // 3: bounce on key 1, every low burst shorter than the debounce window
        keys_n[1] = 1'b0; step(3);
        keys_n[1] = 1'b1; step(2);
        keys_n[1] = 1'b0; step(3);
        keys_n[1] = 1'b1; step(12);
        chk("bounce_pressed1", 10'(pressed[1]), 10'b0);

        // 4: long press with auto-repeat; repeat due on release cycle is suppressed
        c = cyc;
        keys_n[0] = 1'b0;
        push(c + 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        push(c + 26, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
        for (int k = 0; k < 5; k++)
            push(c + 31 + 5 * k, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push(c + 56, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step(40);
        chk("hold_mid", 10'({pressed[0], hold[0]}), 10'b11);
        step(10);
        keys_n[0] = 1'b1;
        step(12);
        chk("hold_cleared", 10'(hold), 10'b0);

        // 5: simultaneous press, then independent release
        c = cyc;
        keys_n = 2'b00;
        push(c + 6,  2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        push(c + 16, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00);
        push(c + 26, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        push(c + 31, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10);
        push(c + 36, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10);
        push(c + 39, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        step(10);
        keys_n[0] = 1'b1;
        step(23);
        keys_n[1] = 1'b1;
        step(12);

        // 6: reset mid-hold with key still down
        c = cyc;
        keys_n[0] = 1'b0;
        push(c + 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        push(c + 26, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
        push(c + 31, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        step(33);
        reset = 1'b0;
        push(c + 34, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        #1;
        chk("reset_async", {pressed, press_pulse, release_pulse, hold, repeat_pulse}, 10'b0);
        step(3);
        reset = 1'b1;
        d = cyc;
        push(d + 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        push(d + 26, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
        push(d + 31, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push(d + 36, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push(d + 40, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step(34);
        keys_n[0] = 1'b1;
        step(12);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events left=%0d next_cyc=%0d", exp_q.size(), exp_q[0].cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
